// File: rtl/debounce_filter.sv
// rtl/debounce_filter.sv - tick-sampled push-button debounce filter with rise/fall pulses
module debounce_filter #(
    parameter int STABLE_TICKS = 4,
    parameter int CNT_W        = 8
) (
    input  logic clk,
    input  logic rst_a_n,
    input  logic tick_in,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_rise,
    output logic btn_fall,
    output logic busy
);

    typedef enum logic [1:0] {
        ST_LOW,
        ST_CHK_HIGH,
        ST_HIGH,
        ST_CHK_LOW
    } state_t;

    // Qualification completes on the tick where cnt+1 reaches STABLE_TICKS.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             s1, s2;
    logic             level_nxt, rise_nxt, fall_nxt;

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn_raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge rst_a_n) begin
        if (!rst_a_n) begin
            state     <= ST_LOW;
            cnt       <= '0;
            btn_level <= 1'b0;
            btn_rise  <= 1'b0;
            btn_fall  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            btn_level <= level_nxt;
            btn_rise  <= rise_nxt;
            btn_fall  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = btn_level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (tick_in) begin
            case (state)
                ST_LOW: begin
                    if (s2) begin
                        state_nxt = ST_CHK_HIGH;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                ST_CHK_HIGH: begin
                    if (!s2) begin
                        state_nxt = ST_LOW;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = '0;
                        level_nxt = 1'b1;
                        rise_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!s2) begin
                        state_nxt = ST_CHK_LOW;
                        cnt_nxt   = CNT_ONE;
                    end
                end
                ST_CHK_LOW: begin
                    if (s2) begin
                        state_nxt = ST_HIGH;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = ST_LOW;
                        cnt_nxt   = '0;
                        level_nxt = 1'b0;
                        fall_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_LOW;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    assign busy = (state == ST_CHK_HIGH) || (state == ST_CHK_LOW);

endmodule

// File: tb/tb_debounce_filter.sv
// tb/tb_debounce_filter.sv - scoreboard bench for debounce_filter
module tb_debounce_filter;

    typedef struct packed {
        logic [1:0]  src;
        logic        rise;
        logic [31:0] edge_n;
    } ev_t;

    localparam int P2 = 101;

    logic clk = 1'b0;
    logic rst_a_n = 1'b0;
    logic tick = 1'b0, raw = 1'b0;
    logic level1, rise1, fall1, busy1;
    logic tick2 = 1'b0, raw2 = 1'b0;
    logic level2, rise2, fall2, busy2;

    int   n_checks = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    int   both_cnt = 0;
    ev_t  exp_q[$];
    ev_t  obs_q[$];
    ev_t  e, o;

    debounce_filter #(.STABLE_TICKS(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_a_n(rst_a_n), .tick_in(tick), .btn_raw(raw),
        .btn_level(level1), .btn_rise(rise1), .btn_fall(fall1), .busy(busy1)
    );

    debounce_filter #(.STABLE_TICKS(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .rst_a_n(rst_a_n), .tick_in(tick2), .btn_raw(raw2),
        .btn_level(level2), .btn_rise(rise2), .btn_fall(fall2), .busy(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Records every output pulse with the index of the rising edge that produced it.
    always @(negedge clk) begin
        if (rise1) obs_q.push_back('{src: 2'd0, rise: 1'b1, edge_n: edge_cnt});
        if (fall1) obs_q.push_back('{src: 2'd0, rise: 1'b0, edge_n: edge_cnt});
        if (rise2) obs_q.push_back('{src: 2'd1, rise: 1'b1, edge_n: edge_cnt});
        if (fall2) obs_q.push_back('{src: 2'd1, rise: 1'b0, edge_n: edge_cnt});
        if ((rise1 && fall1) || (rise2 && fall2)) both_cnt++;
    end

    task automatic step(input logic t);
        tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int base;
        rst_a_n = 1'b0;
        raw = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1);
        n_checks++;
        if ({level1, rise1, fall1, busy1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 0000", {level1, rise1, fall1, busy1});
        end
        rst_a_n = 1'b1;
        base = edge_cnt;
        exp_q.push_back('{src: 2'd0, rise: 1'b1, edge_n: base + 6});
        for (int k = 1; k <= 8; k++) begin
            step(1'b1);
            n_checks++;
            if (busy1 !== (k >= 3 && k <= 5)) begin
                n_fail++;
                $display("FAIL reset_busy_edge%0d: got %b, expected %b", k, busy1, (k >= 3 && k <= 5));
            end
            n_checks++;
            if (level1 !== (k >= 6)) begin
                n_fail++;
                $display("FAIL reset_level_edge%0d: got %b, expected %b", k, level1, (k >= 6));
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_rise_event: got src=%0d rise=%0b edge=%0d, expected src=%0d rise=%0b edge=%0d",
                         o.src, o.rise, o.edge_n, e.src, e.rise, e.edge_n);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_extra_events: got %0d, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_release();
        int base;
        base = edge_cnt;
        exp_q.push_back('{src: 2'd0, rise: 1'b0, edge_n: base + 34});
        raw = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            if (i == 0) begin
                n_checks++;
                if (busy1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL release_busy: got %b, expected 1", busy1);
                end
            end
            for (int j = 0; j < 9; j++) step(1'b0);
        end
        n_checks++;
        if (level1 !== 1'b0) begin
            n_fail++;
            $display("FAIL release_level: got %b, expected 0", level1);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL release_fall_event: got src=%0d rise=%0b edge=%0d, expected src=%0d rise=%0b edge=%0d",
                         o.src, o.rise, o.edge_n, e.src, e.rise, e.edge_n);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL release_extra_events: got %0d, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_bounce();
        raw = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            if (i == 2) begin
                n_checks++;
                if (busy1 !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bounce_busy_qual: got %b, expected 1", busy1);
                end
                raw = 1'b0;
            end
            for (int j = 0; j < 9; j++) step(1'b0);
        end
        step(1'b1);
        n_checks++;
        if ({level1, busy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL bounce_abort: got level,busy=%b, expected 00", {level1, busy1});
        end
        for (int j = 0; j < 5; j++) step(1'b0);
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_no_pulse: got %0d events, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_glitch();
        int busy_seen;
        busy_seen = 0;
        raw = 1'b0;
        step(1'b1);
        step(1'b0);
        raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            if (busy1) busy_seen++;
        end
        raw = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            if (busy1) busy_seen++;
        end
        step(1'b1);
        if (busy1) busy_seen++;
        step(1'b0);
        if (busy1) busy_seen++;
        n_checks++;
        if (busy_seen != 0) begin
            n_fail++;
            $display("FAIL glitch_busy: got %0d busy cycles, expected 0", busy_seen);
        end
        n_checks++;
        if (level1 !== 1'b0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_level: got level=%b events=%0d, expected level=0 events=0", level1, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid();
        int base;
        raw = 1'b1;
        for (int i = 0; i < 5; i++) step(1'b1);
        n_checks++;
        if (busy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy_before: got %b, expected 1", busy1);
        end
        rst_a_n = 1'b0;
        #1;
        n_checks++;
        if ({level1, rise1, fall1, busy1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_async: got %b, expected 0000", {level1, rise1, fall1, busy1});
        end
        step(1'b1);
        step(1'b1);
        rst_a_n = 1'b1;
        base = edge_cnt;
        exp_q.push_back('{src: 2'd0, rise: 1'b1, edge_n: base + 6});
        for (int i = 0; i < 5; i++) step(1'b1);
        n_checks++;
        if (level1 !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_requal_early: got %b, expected 0", level1);
        end
        step(1'b1);
        n_checks++;
        if (level1 !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_requal_level: got %b, expected 1", level1);
        end
        step(1'b1);
        raw = 1'b0;
        base = edge_cnt;
        exp_q.push_back('{src: 2'd0, rise: 1'b0, edge_n: base + 6});
        for (int i = 0; i < 8; i++) step(1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL midreset_event: got src=%0d rise=%0b edge=%0d, expected src=%0d rise=%0b edge=%0d",
                         o.src, o.rise, o.edge_n, e.src, e.rise, e.edge_n);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL midreset_extra_events: got %0d, expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_integration();
        int base, press, rel, t1, t2;
        press = 30;
        rel   = 400;
        t1 = ((press + 2 + P2 - 1) / P2) * P2;
        t2 = ((rel + 2 + P2 - 1) / P2) * P2;
        tick = 1'b0;
        base = edge_cnt;
        exp_q.push_back('{src: 2'd1, rise: 1'b1, edge_n: base + t1 + P2 + 1});
        exp_q.push_back('{src: 2'd1, rise: 1'b0, edge_n: base + t2 + P2 + 1});
        for (int c = 0; c < 700; c++) begin
            tick2 = ((c % P2) == 0);
            raw2  = (c >= press && c < rel);
            @(posedge clk);
            #1;
        end
        tick2 = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = '0;
            if (obs_q.size() > 0) o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL integ_event: got src=%0d rise=%0b edge=%0d, expected src=%0d rise=%0b edge=%0d",
                         o.src, o.rise, o.edge_n, e.src, e.rise, e.edge_n);
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL integ_extra_events: got %0d, expected 0", obs_q.size());
        end
        obs_q.delete();
        n_checks++;
        if (both_cnt != 0) begin
            n_fail++;
            $display("FAIL rise_fall_exclusive: got %0d overlaps, expected 0", both_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_release();
        test_bounce();
        test_glitch();
        test_reset_mid();
        test_integration();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
